// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Holds the program counter, presents it to
// instruction memory (combinational read), and produces the values that are
// latched into the IF/ID pipeline register: instruction, pc, branch prediction,
// a "first fetch" marker and a fetch sequence number.
//
// Branch prediction uses a direct-mapped BTB of 2-bit saturating counters,
// trained by branch resolutions coming back from EX. EX also redirects the PC
// via flush when it detects a misprediction.
//
// Build option:
//   FETCH_BTB_EN  defined   -> BTB present and used for next-PC prediction.
//                 undefined -> no BTB; prediction outputs are tied to 0, the
//                              update_* inputs are ignored and the PC simply
//                              steps by PC_STEP unless flushed.
//
// Ports:
//   clk                       clock, all state changes on rising edge
//   reset                     synchronous active-high reset
//   stall                     hold pc / id / first
//   flush, flush_address      redirect to flush_address (wins over stall)
//   update_valid/pc/taken/target  branch resolution from EX, trains the BTB
//   imem_addr, imem_data      instruction memory address / same-cycle data
//   instruction_out           instruction for the current pc
//   pc_out                    current pc
//   branch_taken_out          prediction for the current pc
//   branch_taken_address_out  predicted target, 0 when not predicted taken
//   first_out                 first fetch after reset or redirect
//   id_out                    fetch sequence number, 0 reserved for bubbles
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INST_WIDTH  = 32,
    parameter int                    BTB_ENTRIES = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [ADDR_WIDTH-1:0] PC_STEP     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_address,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic                  update_taken,
    input  logic [ADDR_WIDTH-1:0] update_target,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_data,
    output logic [INST_WIDTH-1:0] instruction_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  branch_taken_out,
    output logic [ADDR_WIDTH-1:0] branch_taken_address_out,
    output logic                  first_out,
    output logic [51:0]           id_out
);

    localparam int ID_WIDTH = 52;

    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ID_WIDTH-1:0]   id_reg;
    logic [ID_WIDTH-1:0]   id_next;
    logic [ID_WIDTH-1:0]   id_inc;
    logic                  first_reg;
    logic                  first_next;

    // Prediction for the current pc (same-cycle lookup).
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;

`ifdef FETCH_BTB_EN
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;

    logic [BTB_ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]       tag_reg    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0]  target_reg [BTB_ENTRIES];
    logic [1:0]             ctr_reg    [BTB_ENTRIES];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign look_idx = pc_reg[IDX_W-1:0];
    assign look_tag = pc_reg[ADDR_WIDTH-1:IDX_W];
    assign look_hit = valid_reg[look_idx] && (tag_reg[look_idx] == look_tag);

    // Lookup reads the registered contents, so an update to the same entry
    // in this cycle only becomes visible on the next lookup.
    assign pred_taken  = look_hit && ctr_reg[look_idx][1];
    assign pred_target = target_reg[look_idx];

    assign upd_idx = update_pc[IDX_W-1:0];
    assign upd_tag = update_pc[ADDR_WIDTH-1:IDX_W];
    assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

    // Training runs regardless of stall/flush; only reset blocks it.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= '0;
        end else if (update_valid) begin
            if (upd_hit) begin
                if (update_taken) begin
                    if (ctr_reg[upd_idx] != 2'b11) begin
                        ctr_reg[upd_idx] <= ctr_reg[upd_idx] + 2'd1;
                    end
                    target_reg[upd_idx] <= update_target;
                end else if (ctr_reg[upd_idx] != 2'b00) begin
                    ctr_reg[upd_idx] <= ctr_reg[upd_idx] - 2'd1;
                end
            end else if (update_taken) begin
                // Allocate weakly taken, evicting whatever lived at this index.
                valid_reg[upd_idx]  <= 1'b1;
                tag_reg[upd_idx]    <= upd_tag;
                target_reg[upd_idx] <= update_target;
                ctr_reg[upd_idx]    <= 2'b10;
            end
        end
    end
`else
    logic unused_update;

    assign pred_taken    = 1'b0;
    assign pred_target   = '0;
    assign unused_update = ^{update_valid, update_pc, update_taken, update_target};
`endif

    // Sequence number wraps from all-ones straight to 1, keeping 0 free for bubbles.
    assign id_inc = (id_reg == '1) ? ID_WIDTH'(1) : id_reg + ID_WIDTH'(1);

    always_comb begin
        pc_next    = pc_reg;
        id_next    = id_reg;
        first_next = first_reg;
        if (flush) begin
            pc_next    = flush_address;
            id_next    = id_inc;
            first_next = 1'b1;
        end else if (!stall) begin
            pc_next    = pred_taken ? pred_target : pc_reg + PC_STEP;
            id_next    = id_inc;
            first_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            id_reg    <= ID_WIDTH'(1);
            first_reg <= 1'b1;
        end else begin
            pc_reg    <= pc_next;
            id_reg    <= id_next;
            first_reg <= first_next;
        end
    end

    assign imem_addr                = pc_reg;
    assign pc_out                   = pc_reg;
    assign instruction_out          = imem_data;
    assign branch_taken_out         = pred_taken;
    assign branch_taken_address_out = pred_taken ? pred_target : '0;
    assign first_out                = first_reg;
    assign id_out                   = id_reg;

endmodule
